// File: rtl/ssd13xx_cmd_engine_if.sv
// Byte-stream / framebuffer-write bundle for the SSD13xx command engine.
// Latency: none, wires only.
// Backpressure: none; bytes are strobes and the engine always accepts them.
// Ports: byte_valid_i/byte_i/dc_i carry received SPI bytes toward the engine;
//        mem_we_o/mem_addr_o/mem_data_o carry framebuffer writes away from it.
interface ssd13xx_cmd_engine_if #(
  parameter int ADDR_W = 10
);
  logic              byte_valid_i;
  logic [7:0]        byte_i;
  logic              dc_i;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [7:0]        mem_data_o;

  // Byte source / framebuffer sink side.
  modport master (
    output byte_valid_i, byte_i, dc_i,
    input  mem_we_o, mem_addr_o, mem_data_o
  );

  // Command engine side.
  modport slave (
    input  byte_valid_i, byte_i, dc_i,
    output mem_we_o, mem_addr_o, mem_data_o
  );
endinterface

// File: rtl/ssd13xx_cmd_engine.sv
// SSD13xx-style command parser and framebuffer address generator.
// Latency: command effects, framebuffer writes and abort pulses appear one cycle after the final byte.
// Backpressure: none; one byte per cycle is always accepted.
// Ports: clk_i, rst_i (async, active-high); bus (slave) carries the byte stream in
//        and framebuffer writes out; display flags, contrast_o, start_line_o,
//        addr_mode_o are registered state; cmd_abort_o pulses when a data byte
//        cuts off a command that was still collecting arguments.
module ssd13xx_cmd_engine #(
  parameter int COLS  = 128,
  parameter int PAGES = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  ssd13xx_cmd_engine_if.slave bus,
  output logic                disp_on_o,
  output logic                invert_o,
  output logic                all_on_o,
  output logic                seg_remap_o,
  output logic                com_dec_o,
  output logic [7:0]          contrast_o,
  output logic [5:0]          start_line_o,
  output logic [1:0]          addr_mode_o,
  output logic                cmd_abort_o
);

  localparam int CA_W = $clog2(COLS);
  localparam int PA_W = $clog2(PAGES);

  localparam logic [1:0] MODE_HORZ = 2'd0;
  localparam logic [1:0] MODE_VERT = 2'd1;
  localparam logic [1:0] MODE_PAGE = 2'd2;

  typedef enum logic {ST_OPCODE, ST_ARGS} state_t;

  function automatic logic [2:0] arg_count(input logic [7:0] op);
    case (op)
      8'h20, 8'h81, 8'h8D, 8'hA8, 8'hD3,
      8'hD5, 8'hD9, 8'hDA, 8'hDB:         return 3'd1;
      8'h21, 8'h22, 8'hA3:                return 3'd2;
      8'h29, 8'h2A:                       return 3'd5;
      8'h26, 8'h27:                       return 3'd6;
      default:                            return 3'd0;
    endcase
  endfunction

  state_t           state_q, state_d;
  logic [2:0]       arg_cnt_q, arg_cnt_d;
  logic [7:0]       cmd_q, cmd_d;
  logic [7:0]       arg_prev_q;   // previous argument byte; first arg of 2-arg commands
  logic             fire;         // a complete command takes effect at this edge
  logic [7:0]       fire_op;
  logic             abort;
  logic             wr;

  logic [CA_W-1:0]  col_start_q, col_end_q, col_ptr_q, col_nx, col_step;
  logic [PA_W-1:0]  page_start_q, page_end_q, page_ptr_q, page_nx, page_step;
  logic             col_at_end, page_at_end;

  assign wr = bus.byte_valid_i & bus.dc_i;

  // ---------------- parser FSM ----------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_OPCODE;
      arg_cnt_q <= 3'd0;
      cmd_q     <= 8'h00;
    end else begin
      state_q   <= state_d;
      arg_cnt_q <= arg_cnt_d;
      cmd_q     <= cmd_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    arg_cnt_d = arg_cnt_q;
    cmd_d     = cmd_q;
    fire      = 1'b0;
    fire_op   = 8'h00;
    abort     = 1'b0;
    if (bus.byte_valid_i) begin
      if (bus.dc_i) begin
        // Data always wins: any half-received command is dropped.
        abort     = (state_q == ST_ARGS);
        state_d   = ST_OPCODE;
        arg_cnt_d = 3'd0;
      end else begin
        case (state_q)
          ST_OPCODE: begin
            if (arg_count(bus.byte_i) == 3'd0) begin
              fire    = 1'b1;
              fire_op = bus.byte_i;
            end else begin
              state_d   = ST_ARGS;
              arg_cnt_d = arg_count(bus.byte_i);
              cmd_d     = bus.byte_i;
            end
          end
          ST_ARGS: begin
            arg_cnt_d = arg_cnt_q - 3'd1;
            if (arg_cnt_q == 3'd1) begin
              fire    = 1'b1;
              fire_op = cmd_q;
              state_d = ST_OPCODE;
            end
          end
          default: state_d = ST_OPCODE;
        endcase
      end
    end
  end

  // ---------------- pointer advance ----------------
  assign col_at_end  = (col_ptr_q == col_end_q);
  assign page_at_end = (page_ptr_q == page_end_q);
  // Increment wraps naturally at the power-of-two size; the window end wraps to its start.
  assign col_step    = col_at_end  ? col_start_q  : col_ptr_q  + CA_W'(1);
  assign page_step   = page_at_end ? page_start_q : page_ptr_q + PA_W'(1);

  always_comb begin
    col_nx  = col_ptr_q;
    page_nx = page_ptr_q;
    case (addr_mode_o)
      MODE_HORZ: begin
        col_nx = col_step;
        if (col_at_end) page_nx = page_step;
      end
      MODE_VERT: begin
        page_nx = page_step;
        if (page_at_end) col_nx = col_step;
      end
      default: col_nx = col_ptr_q + CA_W'(1);
    endcase
  end

  // ---------------- state registers and effects ----------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      arg_prev_q     <= 8'h00;
      bus.mem_we_o   <= 1'b0;
      bus.mem_addr_o <= '0;
      bus.mem_data_o <= 8'h00;
      cmd_abort_o    <= 1'b0;
      disp_on_o      <= 1'b0;
      invert_o       <= 1'b0;
      all_on_o       <= 1'b0;
      seg_remap_o    <= 1'b0;
      com_dec_o      <= 1'b0;
      contrast_o     <= 8'h7F;
      start_line_o   <= 6'd0;
      addr_mode_o    <= MODE_PAGE;
      col_start_q    <= '0;
      col_end_q      <= CA_W'(COLS - 1);
      page_start_q   <= '0;
      page_end_q     <= PA_W'(PAGES - 1);
      col_ptr_q      <= '0;
      page_ptr_q     <= '0;
    end else begin
      bus.mem_we_o <= wr;
      cmd_abort_o  <= abort;
      if (bus.byte_valid_i && !bus.dc_i && state_q == ST_ARGS)
        arg_prev_q <= bus.byte_i;

      if (wr) begin
        bus.mem_addr_o <= {page_ptr_q, col_ptr_q};
        bus.mem_data_o <= bus.byte_i;
        col_ptr_q      <= col_nx;
        page_ptr_q     <= page_nx;
      end else if (fire) begin
        // For argument commands bus.byte_i is the last argument here.
        casez (fire_op)
          8'hAE: disp_on_o   <= 1'b0;
          8'hAF: disp_on_o   <= 1'b1;
          8'hA6: invert_o    <= 1'b0;
          8'hA7: invert_o    <= 1'b1;
          8'hA4: all_on_o    <= 1'b0;
          8'hA5: all_on_o    <= 1'b1;
          8'hA0: seg_remap_o <= 1'b0;
          8'hA1: seg_remap_o <= 1'b1;
          8'hC0: com_dec_o   <= 1'b0;
          8'hC8: com_dec_o   <= 1'b1;
          8'b01??_????: start_line_o <= fire_op[5:0];
          8'h81: contrast_o <= bus.byte_i;
          8'h20: if (bus.byte_i[1:0] != 2'b11) addr_mode_o <= bus.byte_i[1:0];
          8'h21: begin
            col_start_q <= CA_W'(arg_prev_q);
            col_end_q   <= CA_W'(bus.byte_i);
            col_ptr_q   <= CA_W'(arg_prev_q);
          end
          8'h22: begin
            page_start_q <= PA_W'(arg_prev_q);
            page_end_q   <= PA_W'(bus.byte_i);
            page_ptr_q   <= PA_W'(arg_prev_q);
          end
          // Page-mode pointer shortcuts; zero-arg so bus.byte_i is the opcode.
          8'b0000_????: if (addr_mode_o == MODE_PAGE)
                          col_ptr_q <= {col_ptr_q[CA_W-1:4], bus.byte_i[3:0]};
          8'b0001_????: if (addr_mode_o == MODE_PAGE)
                          col_ptr_q <= CA_W'({bus.byte_i[3:0], col_ptr_q[3:0]});
          8'b1011_????: if (addr_mode_o == MODE_PAGE)
                          page_ptr_q <= PA_W'(bus.byte_i[3:0]);
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ssd13xx_cmd_engine.sv
// Randomized scoreboard bench for ssd13xx_cmd_engine against a byte-queue reference model.
module tb_ssd13xx_cmd_engine;
  localparam int COLS  = 128;
  localparam int PAGES = 8;
  localparam int AW    = 10;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       disp_on_o, invert_o, all_on_o, seg_remap_o, com_dec_o, cmd_abort_o;
  logic [7:0] contrast_o;
  logic [5:0] start_line_o;
  logic [1:0] addr_mode_o;

  ssd13xx_cmd_engine_if #(.ADDR_W(AW)) bus();

  ssd13xx_cmd_engine #(.COLS(COLS), .PAGES(PAGES)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .bus          (bus),
    .disp_on_o    (disp_on_o),
    .invert_o     (invert_o),
    .all_on_o     (all_on_o),
    .seg_remap_o  (seg_remap_o),
    .com_dec_o    (com_dec_o),
    .contrast_o   (contrast_o),
    .start_line_o (start_line_o),
    .addr_mode_o  (addr_mode_o),
    .cmd_abort_o  (cmd_abort_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input bit ok, input string name, input string detail);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: %s", name, detail);
  endtask

  // ---------------- reference model ----------------
  bit m_disp, m_inv, m_allon, m_seg, m_com;
  int m_contrast, m_start, m_mode;
  int cs, ce, ps, pe, cp, pp;
  int cmd_buf[$];
  int exp_addr[$];
  int exp_data[$];
  int exp_abort[$];

  function automatic int nargs(input int op);
    case (op)
      'h20, 'h81, 'h8D, 'hA8, 'hD3, 'hD5, 'hD9, 'hDA, 'hDB: return 1;
      'h21, 'h22, 'hA3: return 2;
      'h29, 'h2A:       return 5;
      'h26, 'h27:       return 6;
      default:          return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_disp = 0; m_inv = 0; m_allon = 0; m_seg = 0; m_com = 0;
    m_contrast = 'h7F; m_start = 0; m_mode = 2;
    cs = 0; ce = COLS - 1; ps = 0; pe = PAGES - 1; cp = 0; pp = 0;
    cmd_buf.delete();
    exp_addr.delete(); exp_data.delete(); exp_abort.delete();
  endtask

  task automatic model_apply();
    int op;
    op = cmd_buf[0];
    if (op >= 'h40 && op <= 'h7F) m_start = op % 64;
    case (op)
      'hAE: m_disp = 0;   'hAF: m_disp = 1;
      'hA6: m_inv = 0;    'hA7: m_inv = 1;
      'hA4: m_allon = 0;  'hA5: m_allon = 1;
      'hA0: m_seg = 0;    'hA1: m_seg = 1;
      'hC0: m_com = 0;    'hC8: m_com = 1;
      'h81: m_contrast = cmd_buf[1];
      'h20: if (cmd_buf[1] % 4 != 3) m_mode = cmd_buf[1] % 4;
      'h21: begin cs = cmd_buf[1] % COLS;  ce = cmd_buf[2] % COLS;  cp = cs; end
      'h22: begin ps = cmd_buf[1] % PAGES; pe = cmd_buf[2] % PAGES; pp = ps; end
      default: ;
    endcase
    if (m_mode == 2) begin
      if (op < 'h10)                    cp = (cp / 16) * 16 + op % 16;
      else if (op < 'h20)               cp = ((op % 16) * 16 + cp % 16) % COLS;
      else if (op >= 'hB0 && op < 'hC0) pp = (op % 16) % PAGES;
    end
  endtask

  task automatic model_byte(input bit dc, input logic [7:0] b);
    if (dc) begin
      if (cmd_buf.size() > 0) begin
        exp_abort.push_back(pp * COLS + cp);
        cmd_buf.delete();
      end
      exp_addr.push_back(pp * COLS + cp);
      exp_data.push_back(int'(b));
      if (m_mode == 0) begin
        if (cp == ce) begin
          cp = cs;
          pp = (pp == pe) ? ps : (pp + 1) % PAGES;
        end else cp = (cp + 1) % COLS;
      end else if (m_mode == 1) begin
        if (pp == pe) begin
          pp = ps;
          cp = (cp == ce) ? cs : (cp + 1) % COLS;
        end else pp = (pp + 1) % PAGES;
      end else cp = (cp + 1) % COLS;
    end else begin
      cmd_buf.push_back(int'(b));
      if (cmd_buf.size() == 1 + nargs(cmd_buf[0])) begin
        model_apply();
        cmd_buf.delete();
      end
    end
  endtask

  task automatic check_flags(input string name);
    logic [20:0] got, want;
    got  = {disp_on_o, invert_o, all_on_o, seg_remap_o, com_dec_o,
            contrast_o, start_line_o, addr_mode_o};
    want = {m_disp, m_inv, m_allon, m_seg, m_com,
            8'(m_contrast), 6'(m_start), 2'(m_mode)};
    check(got == want, name, $sformatf("flags got 0x%06h want 0x%06h", got, want));
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic send(input bit dc, input logic [7:0] b);
    @(negedge clk_i);
    bus.byte_valid_i = 1'b1;
    bus.byte_i       = b;
    bus.dc_i         = dc;
    model_byte(dc, b);
    @(posedge clk_i);
    #1;
    bus.byte_valid_i = 1'b0;
    check_flags("flags");
  endtask

  task automatic cmd(input logic [7:0] b);
    send(1'b0, b);
  endtask

  task automatic data(input logic [7:0] b);
    send(1'b1, b);
  endtask

  task automatic reset_dut();
    repeat (3) @(negedge clk_i);
    check(exp_addr.size() == 0, "writes_drained", $sformatf("got %0d pending want 0", exp_addr.size()));
    check(exp_abort.size() == 0, "aborts_drained", $sformatf("got %0d pending want 0", exp_abort.size()));
    rst_i = 1'b1;
    model_reset();
    @(negedge clk_i);
    check({bus.mem_we_o, bus.mem_addr_o, bus.mem_data_o, cmd_abort_o} == '0, "reset_outputs",
          $sformatf("got we=%0b addr=%0d data=0x%0h abort=%0b want all 0",
                    bus.mem_we_o, bus.mem_addr_o, bus.mem_data_o, cmd_abort_o));
    check_flags("reset_flags");
    rst_i = 1'b0;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk_i) begin
    int ea, ed, ab;
    if (bus.mem_we_o === 1'b1) begin
      if (rst_i || exp_addr.size() == 0)
        check(1'b0, "write_unexpected", $sformatf("got addr %0d data 0x%0h, want no write",
              bus.mem_addr_o, bus.mem_data_o));
      else begin
        ea = exp_addr.pop_front();
        ed = exp_data.pop_front();
        check(int'(bus.mem_addr_o) == ea && int'(bus.mem_data_o) == ed, "write",
              $sformatf("got page %0d col %0d data 0x%0h want page %0d col %0d data 0x%0h",
                        int'(bus.mem_addr_o) / COLS, int'(bus.mem_addr_o) % COLS,
                        bus.mem_data_o, ea / COLS, ea % COLS, ed));
      end
    end
    if (cmd_abort_o === 1'b1) begin
      if (exp_abort.size() == 0)
        check(1'b0, "abort_unexpected", "got abort pulse want none");
      else begin
        ab = exp_abort.pop_front();
        check(bus.mem_we_o === 1'b1 && int'(bus.mem_addr_o) == ab, "abort",
              $sformatf("got abort with we=%0b addr %0d want we=1 addr %0d",
                        bus.mem_we_o, bus.mem_addr_o, ab));
      end
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [7:0] flag_ops [10] = '{8'hAE, 8'hAF, 8'hA6, 8'hA7, 8'hA4, 8'hA5, 8'hA0, 8'hA1, 8'hC0, 8'hC8};
    logic [7:0] arg_ops  [13] = '{8'h81, 8'h8D, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB,
                                  8'hA3, 8'h29, 8'h2A, 8'h26, 8'h27};
    rst_i            = 1'b1;
    bus.byte_valid_i = 1'b0;
    bus.byte_i       = 8'h00;
    bus.dc_i         = 1'b0;
    model_reset();
    repeat (2) @(negedge clk_i);
    check({bus.mem_we_o, bus.mem_addr_o, bus.mem_data_o, cmd_abort_o} == '0, "power_on_outputs",
          $sformatf("got we=%0b addr=%0d data=0x%0h abort=%0b want all 0",
                    bus.mem_we_o, bus.mem_addr_o, bus.mem_data_o, cmd_abort_o));
    check_flags("power_on_flags");
    rst_i = 1'b0;

    // Flag commands and a one-argument command.
    cmd(8'hAF); cmd(8'hA7); cmd(8'h81); cmd(8'h33);
    check(contrast_o == 8'h33, "contrast_0x33", $sformatf("got 0x%0h want 0x33", contrast_o));

    // Horizontal window wrap across pages.
    cmd(8'h20); cmd(8'h00);
    cmd(8'h21); cmd(8'h7E); cmd(8'h7F);
    cmd(8'h22); cmd(8'h06); cmd(8'h07);
    for (int i = 0; i < 5; i++) data(8'(8'h10 + i));

    // Vertical window wrap across columns.
    cmd(8'h20); cmd(8'h01);
    cmd(8'h21); cmd(8'h00); cmd(8'h01);
    cmd(8'h22); cmd(8'h00); cmd(8'h01);
    for (int i = 0; i < 5; i++) data(8'(8'h20 + i));

    // Page mode pointer commands, column wraps at COLS.
    reset_dut();
    cmd(8'hB3); cmd(8'h05); cmd(8'h11); cmd(8'h0F); cmd(8'h17);
    data(8'h5A); data(8'hA5);

    // Data byte aborts a pending command.
    cmd(8'h81); data(8'hAA);
    check(contrast_o == 8'h7F, "contrast_kept", $sformatf("got 0x%0h want 0x7f", contrast_o));
    cmd(8'hAE);

    // Scroll arguments are swallowed; reset drops a partial window command.
    cmd(8'h26);
    for (int i = 0; i < 6; i++) cmd(8'hAF);
    cmd(8'hAF);
    cmd(8'h20); cmd(8'h00); cmd(8'h21); cmd(8'h10);
    reset_dut();
    cmd(8'h20); cmd(8'h00);
    for (int i = 0; i < 130; i++) data(8'($urandom));

    // Randomized mix.
    for (int it = 0; it < 400; it++) begin
      int r, op, n, k;
      r = int'($urandom_range(0, 99));
      if (r < 35) data(8'($urandom));
      else if (r < 45) begin
        cmd(($urandom_range(0, 1) == 0) ? 8'h21 : 8'h22);
        cmd(8'($urandom)); cmd(8'($urandom));
      end else if (r < 53) begin
        cmd(8'h20); cmd(8'($urandom_range(0, 3)));
      end else if (r < 63) begin
        k = int'($urandom_range(0, 2));
        cmd(k == 0 ? 8'($urandom_range(0, 15)) :
            k == 1 ? 8'($urandom_range(16, 31)) : 8'($urandom_range(176, 191)));
      end else if (r < 73) begin
        if ($urandom_range(0, 3) == 0) cmd(8'($urandom_range(64, 127)));
        else cmd(flag_ops[$urandom_range(0, 9)]);
      end else if (r < 88) begin
        op = int'(arg_ops[$urandom_range(0, 12)]);
        n  = nargs(op);
        k  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : n;
        cmd(8'(op));
        for (int j = 0; j < k; j++) cmd(8'($urandom));
        if (k < n) data(8'($urandom));
      end else begin
        op = int'($urandom_range(0, 255));
        cmd(8'(op));
        for (int j = 0; j < nargs(op); j++) cmd(8'($urandom));
      end
      if (it == 200) reset_dut();
    end

    repeat (3) @(negedge clk_i);
    check(exp_addr.size() == 0, "final_writes", $sformatf("got %0d outstanding want 0", exp_addr.size()));
    check(exp_abort.size() == 0, "final_aborts", $sformatf("got %0d outstanding want 0", exp_abort.size()));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
